// File: rtl/usb_wr_arb_pkg.sv
// Shared types and constants for the FX3 DMA0 write arbiter.
package usb_wr_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        XFER  = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Owner codes double as the one-hot gnt encoding.
    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_VID  = 2'b01;
    localparam logic [1:0] OWN_PKT  = 2'b10;

    localparam int PAUSE_TIMEOUT_DEF = 6;

endpackage

// File: rtl/usb_wr_arbiter_flag_sync.sv
// Two-flop synchronizer for raw FX3 DMA flags; shared with the read-side controller.
module flag_sync #(
    parameter int W = 2
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_meta;
    logic [W-1:0] r_sync;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/usb_wr_arbiter.sv
// Burst arbiter for the FX3 slave-FIFO write channel (video vs. packet source).
// Optional starvation guard for the packet source: define USB_WR_ARB_STARVE_EN.
//
//   state | meaning
//   IDLE  | wait for DMA0 ready, pick/resume an owner
//   XFER  | owner pops one word per cycle toward the pins
//   PAUSE | watermark hit, burst suspended (owner/remaining held)
//   DONE  | burst finished, release owner and lock
module usb_wr_arbiter
    import usb_wr_arb_pkg::*;
#(
    parameter int WORDS         = 1281,
    parameter int PAUSE_TIMEOUT = PAUSE_TIMEOUT_DEF,
    parameter int STARVE_LIMIT  = 4
) (
    input  logic        USB_CLK,
    input  logic        rst,
    input  logic        DMA0_Ready,
    input  logic        DMA0_Watermark,
    input  logic        req0,
    input  logic [15:0] req0_data,
    output logic        req0_rd,
    input  logic        req1,
    input  logic [7:0]  req1_len,
    input  logic [15:0] req1_data,
    output logic        req1_rd,
    output logic        WR,
    output logic        LastWRData,
    output logic        DQ_oe,
    output logic [15:0] DQ_out,
    output logic [1:0]  gnt,
    output logic        err_zero_len
);

    localparam int PCW = (PAUSE_TIMEOUT > 1) ? $clog2(PAUSE_TIMEOUT) : 1;

    state_t         r_state;
    state_t         w_next;
    logic [1:0]     r_owner;
    logic [1:0]     w_owner_nxt;
    logic [15:0]    r_rem;
    logic           r_lock;
    logic [PCW-1:0] r_pcnt;
    logic           r_zero_blk;
    logic           r_wr;
    logic           r_last;
    logic [15:0]    r_dq;
    logic           r_err;

    logic [1:0]     w_flags_s;
    logic           w_rdy_s;
    logic           w_wm_s;
    logic           w_rd_en;
    logic           w_rd0;
    logic           w_rd1;
    logic           w_last_word;
    logic           w_pkt_ok;
    logic           w_starve;
    logic           w_want_pkt;
    logic           w_load;
    logic [15:0]    w_load_val;
    logic           w_err;
    logic           w_lock_set;
    logic           w_lock_clr;

    flag_sync #(.W(2)) u_flag_sync (
        .i_clk (USB_CLK),
        .i_rst (rst),
        .i_d   ({DMA0_Watermark, DMA0_Ready}),
        .o_q   (w_flags_s)
    );

    assign w_rdy_s = w_flags_s[0];
    assign w_wm_s  = w_flags_s[1];

    // The final word still goes out when the watermark arrives with it.
    assign w_last_word = (r_rem == 16'd1);
    assign w_rd_en     = (r_state == XFER) && (!w_wm_s || w_last_word);
    assign w_rd0       = w_rd_en && (r_owner == OWN_VID);
    assign w_rd1       = w_rd_en && (r_owner == OWN_PKT);

    assign w_pkt_ok   = req1 && !r_zero_blk;
    assign w_want_pkt = w_pkt_ok && (w_starve || !req0);

`ifdef USB_WR_ARB_STARVE_EN
    localparam int SCW = $clog2(STARVE_LIMIT + 1);

    logic [SCW-1:0] r_starve;
    logic           w_vid_grant;
    logic           w_pkt_grant;

    assign w_vid_grant = (r_state == IDLE) && w_load && (w_owner_nxt == OWN_VID);
    assign w_pkt_grant = (r_state == IDLE) && w_load && (w_owner_nxt == OWN_PKT);
    assign w_starve    = (r_starve == SCW'(STARVE_LIMIT));

    always_ff @(posedge USB_CLK or posedge rst) begin
        if (rst) begin
            r_starve <= '0;
        end else if (w_pkt_grant) begin
            r_starve <= '0;
        end else if (w_vid_grant && w_pkt_ok && !w_starve) begin
            r_starve <= r_starve + SCW'(1);
        end
    end
`else
    // Strict video priority; the limit only matters for the guarded build.
    assign w_starve = (STARVE_LIMIT < 0);
`endif

    always_ff @(posedge USB_CLK or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_owner_nxt = r_owner;
        w_load      = 1'b0;
        w_load_val  = 16'd0;
        w_err       = 1'b0;
        w_lock_set  = 1'b0;
        w_lock_clr  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_rdy_s) begin
                    if (r_lock) begin
                        w_next = XFER;
                    end else if (w_want_pkt) begin
                        if (req1_len == 8'd0) begin
                            w_err = 1'b1;
                        end else begin
                            w_next      = XFER;
                            w_owner_nxt = OWN_PKT;
                            w_load      = 1'b1;
                            w_load_val  = {8'h00, req1_len};
                        end
                    end else if (req0) begin
                        w_next      = XFER;
                        w_owner_nxt = OWN_VID;
                        w_load      = 1'b1;
                        w_load_val  = 16'(WORDS);
                    end
                end
            end
            XFER: begin
                if (w_rd_en && w_last_word) begin
                    w_next = DONE;
                end else if (w_wm_s) begin
                    w_next     = PAUSE;
                    w_lock_set = 1'b1;
                end
            end
            PAUSE: begin
                if (!w_rdy_s || (r_pcnt == PCW'(PAUSE_TIMEOUT - 1))) begin
                    w_next = IDLE;
                end
            end
            DONE: begin
                w_next      = IDLE;
                w_owner_nxt = OWN_NONE;
                w_lock_clr  = 1'b1;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge USB_CLK or posedge rst) begin
        if (rst) begin
            r_owner    <= OWN_NONE;
            r_rem      <= 16'd0;
            r_lock     <= 1'b0;
            r_pcnt     <= '0;
            r_zero_blk <= 1'b0;
            r_wr       <= 1'b0;
            r_last     <= 1'b0;
            r_dq       <= 16'd0;
            r_err      <= 1'b0;
        end else begin
            r_owner <= w_owner_nxt;
            if (w_load) begin
                r_rem <= w_load_val;
            end else if (w_rd_en && (r_rem != 16'd0)) begin
                r_rem <= r_rem - 16'd1;
            end
            if (w_lock_clr) begin
                r_lock <= 1'b0;
            end else if (w_lock_set) begin
                r_lock <= 1'b1;
            end
            r_pcnt <= (r_state == PAUSE) ? r_pcnt + PCW'(1) : '0;
            // A zero-length request is reported once and ignored until req1 drops.
            if (!req1) begin
                r_zero_blk <= 1'b0;
            end else if (w_err) begin
                r_zero_blk <= 1'b1;
            end
            r_wr   <= w_rd_en;
            r_last <= w_rd1 && w_last_word;
            r_dq   <= w_rd0 ? req0_data : (w_rd1 ? req1_data : 16'd0);
            r_err  <= w_err;
        end
    end

    assign req0_rd      = w_rd0;
    assign req1_rd      = w_rd1;
    assign WR           = r_wr;
    assign DQ_oe        = r_wr;
    assign LastWRData   = r_last;
    assign DQ_out       = r_dq;
    assign gnt          = r_owner;
    assign err_zero_len = r_err;

endmodule

// File: tb/tb_usb_wr_arbiter.sv
// Scoreboard bench for usb_wr_arbiter: expected pin words queued at stimulus time.
module tb_usb_wr_arbiter;
    import usb_wr_arb_pkg::*;

    localparam int WORDS = 8;

    logic        USB_CLK = 1'b0;
    logic        rst;
    logic        DMA0_Ready, DMA0_Watermark;
    logic        req0, req1;
    logic [15:0] req0_data, req1_data;
    logic [7:0]  req1_len;
    logic        req0_rd, req1_rd;
    logic        WR, LastWRData, DQ_oe;
    logic [15:0] DQ_out;
    logic [1:0]  gnt;
    logic        err_zero_len;

    usb_wr_arbiter #(.WORDS(WORDS), .PAUSE_TIMEOUT(6), .STARVE_LIMIT(2)) dut (
        .USB_CLK(USB_CLK), .rst(rst),
        .DMA0_Ready(DMA0_Ready), .DMA0_Watermark(DMA0_Watermark),
        .req0(req0), .req0_data(req0_data), .req0_rd(req0_rd),
        .req1(req1), .req1_len(req1_len), .req1_data(req1_data), .req1_rd(req1_rd),
        .WR(WR), .LastWRData(LastWRData), .DQ_oe(DQ_oe), .DQ_out(DQ_out),
        .gnt(gnt), .err_zero_len(err_zero_len)
    );

    always #5 USB_CLK = ~USB_CLK;

    typedef struct packed {
        logic [15:0] d;
        logic        last;
    } exp_t;

    exp_t       q_exp[$];
    logic [1:0] g_seq[$];
    int n_cmp = 0, n_bad = 0;
    int vid_idx = 0, pkt_idx = 0, exp_vbase = 0, exp_pbase = 0;
    int wr_cnt = 0, wr_first = -1, wr_last = -1, cyc = 0, err_cnt = 0, rd1_cnt = 0;
    bit chk_en = 1'b0;
    logic p0 = 1'b0, p1 = 1'b0;
    logic [1:0] gnt_prev = 2'b00;
    exp_t m_e;

`ifdef USB_WR_ARB_STARVE_EN
    bit seq_pkt[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
`else
    bit seq_pkt[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`endif

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Show-ahead sources: the word advances after each accepted pop.
    assign req0_data = 16'hA000 + vid_idx[15:0];
    assign req1_data = 16'h5000 + pkt_idx[15:0];

    always @(negedge USB_CLK) begin
        p0 = req0_rd;
        p1 = req1_rd;
    end

    always @(posedge USB_CLK) begin
        #1;
        if (p0) vid_idx++;
        if (p1) pkt_idx++;
    end

    always @(negedge USB_CLK) begin
        cyc++;
        if (!rst && chk_en) begin
            if (WR) begin
                wr_cnt++;
                if (wr_first < 0) wr_first = cyc;
                wr_last = cyc;
                if (q_exp.size() == 0) begin
                    chk("sb_nonempty_on_wr", q_exp.size(), 1);
                end else begin
                    m_e = q_exp.pop_front();
                    chk("dq_out", DQ_out, m_e.d);
                    chk("last_wr", LastWRData, m_e.last);
                end
                chk("dq_oe", DQ_oe, 1);
            end else if (LastWRData || DQ_oe) begin
                chk("strobe_without_wr", {LastWRData, DQ_oe}, 0);
            end
            if (err_zero_len) err_cnt++;
            if (req1_rd) rd1_cnt++;
            if (gnt != 2'b00 && gnt_prev == 2'b00) g_seq.push_back(gnt);
        end
        gnt_prev = gnt;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge USB_CLK);
            #1;
        end
    endtask

    task automatic push_burst(input bit pkt, input int len);
        for (int i = 0; i < len; i++) begin
            exp_t e;
            if (pkt) begin
                e.d = 16'h5000 + exp_pbase[15:0];
                exp_pbase++;
            end else begin
                e.d = 16'hA000 + exp_vbase[15:0];
                exp_vbase++;
            end
            e.last = pkt && (i == len - 1);
            q_exp.push_back(e);
        end
    endtask

    task automatic wait_wr(input int n, input int budget, input string tag);
        int t = 0;
        while (wr_cnt < n && t < budget) begin
            tick(1);
            t++;
        end
        if (wr_cnt < n) chk(tag, wr_cnt, n);
    endtask

    task automatic wait_gnt(input logic [1:0] want, input int budget, input string tag);
        int t = 0;
        while (gnt !== want && t < budget) begin
            tick(1);
            t++;
        end
        chk(tag, gnt, want);
    endtask

    task automatic clear_stats();
        wr_cnt = 0; wr_first = -1; wr_last = -1; err_cnt = 0; rd1_cnt = 0;
        g_seq.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int total;
        rst = 1'b1; DMA0_Ready = 1'b0; DMA0_Watermark = 1'b0;
        req0 = 1'b0; req1 = 1'b0; req1_len = 8'd0;
        tick(3);
        chk("rst_strobes", {WR, LastWRData, DQ_oe, req0_rd, req1_rd, err_zero_len}, 0);
        chk("rst_dq", DQ_out, 0);
        chk("rst_gnt", gnt, OWN_NONE);
        rst = 1'b0;
        DMA0_Ready = 1'b1;
        chk_en = 1'b1;
        tick(4);

        // Plain video burst
        clear_stats();
        push_burst(1'b0, WORDS);
        req0 = 1'b1;
        wait_gnt(OWN_VID, 20, "t1_gnt_vid");
        req0 = 1'b0;
        wait_wr(WORDS, 60, "t1_wr_timeout");
        tick(4);
        chk("t1_wr_count", wr_cnt, WORDS);
        chk("t1_contiguous", wr_last - wr_first + 1, WORDS);
        chk("t1_gnt_released", gnt, OWN_NONE);
        chk("t1_sb_drained", q_exp.size(), 0);

        // Short packet
        clear_stats();
        push_burst(1'b1, 3);
        req1_len = 8'd3;
        req1 = 1'b1;
        wait_gnt(OWN_PKT, 20, "t2_gnt_pkt");
        req1 = 1'b0;
        wait_wr(3, 40, "t2_wr_timeout");
        tick(4);
        chk("t2_wr_count", wr_cnt, 3);
        chk("t2_contiguous", wr_last - wr_first + 1, 3);
        chk("t2_gnt_released", gnt, OWN_NONE);
        chk("t2_sb_drained", q_exp.size(), 0);

        // Watermark suspends video; it resumes ahead of a pending packet
        clear_stats();
        push_burst(1'b0, WORDS);
        push_burst(1'b1, 3);
        req0 = 1'b1;
        wait_gnt(OWN_VID, 20, "t3_gnt_vid");
        req0 = 1'b0;
        wait_wr(3, 40, "t3_wr_pre_wm");
        DMA0_Watermark = 1'b1;
        tick(2);
        req1_len = 8'd3;
        req1 = 1'b1;
        DMA0_Ready = 1'b0;
        tick(5);
        chk("t3_suspended", wr_cnt < WORDS, 1);
        chk("t3_gnt_held", gnt, OWN_VID);
        DMA0_Watermark = 1'b0;
        tick(3);
        DMA0_Ready = 1'b1;
        wait_gnt(OWN_PKT, 100, "t3_gnt_pkt");
        req1 = 1'b0;
        wait_wr(WORDS + 3, 60, "t3_wr_timeout");
        tick(4);
        chk("t3_wr_count", wr_cnt, WORDS + 3);
        chk("t3_grants", g_seq.size(), 2);
        if (g_seq.size() == 2) begin
            chk("t3_grant0", g_seq[0], OWN_VID);
            chk("t3_grant1", g_seq[1], OWN_PKT);
        end
        chk("t3_sb_drained", q_exp.size(), 0);

        // Both requests held: grant order
        clear_stats();
        total = 0;
        for (int i = 0; i < 6; i++) begin
            push_burst(seq_pkt[i], seq_pkt[i] ? 2 : WORDS);
            total += seq_pkt[i] ? 2 : WORDS;
        end
        req1_len = 8'd2;
        req0 = 1'b1;
        req1 = 1'b1;
        for (int t = 0; t < 600 && g_seq.size() < 6; t++) tick(1);
        req0 = 1'b0;
        req1 = 1'b0;
        chk("t4_grant_count", g_seq.size(), 6);
        wait_wr(total, 100, "t4_wr_timeout");
        tick(4);
        for (int i = 0; i < 6 && i < g_seq.size(); i++)
            chk($sformatf("t4_grant%0d", i), g_seq[i], seq_pkt[i] ? OWN_PKT : OWN_VID);
        chk("t4_wr_count", wr_cnt, total);
        chk("t4_sb_drained", q_exp.size(), 0);

        // Zero-length packet request
        clear_stats();
        req1_len = 8'd0;
        req1 = 1'b1;
        tick(10);
        chk("t5_err_once", err_cnt, 1);
        chk("t5_no_wr", wr_cnt, 0);
        chk("t5_no_rd1", rd1_cnt, 0);
        chk("t5_no_gnt", gnt, OWN_NONE);
        req1 = 1'b0;
        tick(3);
        req1 = 1'b1;
        tick(6);
        chk("t5_err_after_drop", err_cnt, 2);
        req1 = 1'b0;
        tick(3);

        // Reset while a resumed (locked) burst is in XFER
        chk_en = 1'b0;
        req0 = 1'b1;
        wait_gnt(OWN_VID, 20, "t6_gnt_vid");
        req0 = 1'b0;
        tick(1);
        DMA0_Watermark = 1'b1;
        tick(8);
        DMA0_Watermark = 1'b0;
        for (int t = 0; t < 40 && req0_rd !== 1'b1; t++) tick(1);
        chk("t6_resumed", req0_rd, 1);
        rst = 1'b1;
        #1;
        chk("t6_rst_strobes", {WR, LastWRData, DQ_oe, req0_rd, req1_rd, err_zero_len}, 0);
        chk("t6_rst_dq", DQ_out, 0);
        chk("t6_rst_gnt", gnt, OWN_NONE);
        tick(2);
        rst = 1'b0;
        q_exp.delete();
        clear_stats();
        tick(4);
        chk_en = 1'b1;
        chk("t6_idle_gnt", gnt, OWN_NONE);
        exp_pbase = pkt_idx;
        push_burst(1'b1, 2);
        req1_len = 8'd2;
        req1 = 1'b1;
        wait_gnt(OWN_PKT, 20, "t6_fresh_pkt_gnt");
        req1 = 1'b0;
        wait_wr(2, 40, "t6_wr_timeout");
        tick(4);
        chk("t6_wr_count", wr_cnt, 2);
        chk("t6_sb_drained", q_exp.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
